mspe_dram_arbiter: RTL and testbench

//  Shares the single 512-bit Avalon-MM DRAM master (m0_*) of mspe among CORES requesters
//  (per-core insn/data fetch and result write-back). Round-robin grant, one transaction in

---
 rtl/mspe_pkg.sv | 14 +
 rtl/mspe_rr_pick.sv | 33 +++
 rtl/mspe_dram_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mspe_dram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mspe_pkg.sv
// mspe_pkg: constants and the DRAM arbiter state type shared across mspe.
package mspe_pkg;

  localparam int M0_DATA_W  = 512;
  localparam int M0_ADDR_W  = 64;
  localparam int M0_BURST_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA
  } arb_state_t;

endpackage

// File: rtl/mspe_rr_pick.sv
// mspe_rr_pick: combinational round-robin picker. Scans the request vector
// starting just after the last granted index, wrapping, and returns the first
// requester as a one-hot grant plus its index.
module mspe_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] candIdx;

  // Walk the candidates in priority order; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    candIdx = '0;
    for (int off = 1; off <= N; off++) begin
      candIdx = IW'((int'(last_i) + off) % N);
      if (!valid_o && req_i[candIdx]) begin
        valid_o          = 1'b1;
        grant_o[candIdx] = 1'b1;
        idx_o            = candIdx;
      end
    end
  end

endmodule

// File: rtl/mspe_dram_arbiter.sv
// mspe_dram_arbiter: shares the single Avalon-MM DRAM master among CORES
// requesters. Round-robin grant, one transaction in flight, read beats are
// steered back to the owner with a one-hot valid.
// Optional statistics counters are built when MSPE_DRAM_ARB_STATS_EN is defined.
module mspe_dram_arbiter
  import mspe_pkg::*;
#(
  parameter int CORES   = 4,
  parameter int ADDR_W  = M0_ADDR_W,
  parameter int DATA_W  = M0_DATA_W,
  parameter int BURST_W = M0_BURST_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CORES-1:0]          req_read,
  input  logic [CORES-1:0]          req_write,
  input  logic [CORES*ADDR_W-1:0]   req_address,
  input  logic [CORES*BURST_W-1:0]  req_burstcount,
  input  logic [CORES*DATA_W-1:0]   req_writedata,
  input  logic [CORES*DATA_W/8-1:0] req_byteenable,
  output logic [CORES-1:0]          req_ack,
  output logic [DATA_W-1:0]         rsp_readdata,
  output logic [CORES-1:0]          rsp_valid,
  output logic                      err_spurious,
  input  logic                      m0_waitrequest,
  input  logic [DATA_W-1:0]         m0_readdata,
  input  logic                      m0_readdatavalid,
  output logic [ADDR_W-1:0]         m0_address,
  output logic [BURST_W-1:0]        m0_burstcount,
  output logic [DATA_W-1:0]         m0_writedata,
  output logic [DATA_W/8-1:0]       m0_byteenable,
  output logic                      m0_read,
  output logic                      m0_write,
  output logic                      m0_debugaccess,
  output logic [CORES*32-1:0]       stat_grants,
  output logic [31:0]               stat_wait_cycles
);

  localparam int IW   = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int BE_W = DATA_W / 8;

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               isRead_q, isRead_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [BURST_W-1:0] beatCnt_q, beatCnt_d;
  logic [CORES-1:0]   rspValid_q, rspValid_d;
  logic [DATA_W-1:0]  rspData_q, rspData_d;
  logic               err_q, err_d;

  logic [CORES-1:0]   pickGrant;
  logic [IW-1:0]      pickIdx;
  logic               pickValid;
  logic [BURST_W-1:0] reqBurst;
  logic               accept;
  logic               stall;

  mspe_rr_pick #(
    .N  (CORES),
    .IW (IW)
  ) uPick (
    .req_i   (req_read | req_write),
    .last_i  (rr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  // Next-state logic: capture the winner in IDLE, hold the command until the
  // slave accepts it, then count read beats back to the owner.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    isRead_d   = isRead_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    beatCnt_d  = beatCnt_q;
    rspValid_d = '0;
    rspData_d  = rspData_q;
    err_d      = err_q | (m0_readdatavalid && (state_q != RDATA));
    reqBurst   = '0;
    req_ack    = '0;
    accept     = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d  = CMD;
          owner_d  = pickIdx;
          isRead_d = |(req_read & pickGrant);
          addr_d   = req_address[pickIdx*ADDR_W +: ADDR_W];
          wdata_d  = req_writedata[pickIdx*DATA_W +: DATA_W];
          be_d     = req_byteenable[pickIdx*BE_W +: BE_W];
          reqBurst = req_burstcount[pickIdx*BURST_W +: BURST_W];
          burst_d  = (isRead_d && (reqBurst != '0)) ? reqBurst : BURST_W'(1);
        end
      end
      CMD: begin
        if (!m0_waitrequest) begin
          req_ack = CORES'(1) << owner_q;
          accept  = 1'b1;
          rr_d    = owner_q;
          if (isRead_q) begin
            state_d   = RDATA;
            beatCnt_d = burst_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stall = 1'b1;
        end
      end
      RDATA: begin
        if (m0_readdatavalid) begin
          rspValid_d = CORES'(1) << owner_q;
          rspData_d  = m0_readdata;
          beatCnt_d  = beatCnt_q - BURST_W'(1);
          if (beatCnt_q == BURST_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset leaves core 0 first in line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_q       <= IW'(CORES - 1);
      owner_q    <= '0;
      isRead_q   <= 1'b0;
      addr_q     <= '0;
      burst_q    <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      beatCnt_q  <= '0;
      rspValid_q <= '0;
      rspData_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      isRead_q   <= isRead_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      beatCnt_q  <= beatCnt_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      err_q      <= err_d;
    end
  end

  assign m0_read        = (state_q == CMD) && isRead_q;
  assign m0_write       = (state_q == CMD) && !isRead_q;
  assign m0_address     = addr_q;
  assign m0_burstcount  = burst_q;
  assign m0_writedata   = wdata_q;
  assign m0_byteenable  = be_q;
  assign m0_debugaccess = 1'b0;
  assign rsp_valid      = rspValid_q;
  assign rsp_readdata   = rspData_q;
  assign err_spurious   = err_q;

`ifdef MSPE_DRAM_ARB_STATS_EN
  logic [31:0] grantCnt_q [CORES];
  logic [31:0] waitCnt_q;

  // Saturating per-core grant counters and stalled-command cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CORES; i++) begin
        grantCnt_q[i] <= '0;
      end
      waitCnt_q <= '0;
    end else begin
      if (accept && (grantCnt_q[owner_q] != '1)) begin
        grantCnt_q[owner_q] <= grantCnt_q[owner_q] + 32'd1;
      end
      if (stall && (waitCnt_q != '1)) begin
        waitCnt_q <= waitCnt_q + 32'd1;
      end
    end
  end

  // Flatten the counters onto the packed statistics port.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < CORES; i++) begin
      stat_grants[i*32 +: 32] = grantCnt_q[i];
    end
  end

  assign stat_wait_cycles = waitCnt_q;
`else
  logic unusedStats;
  assign unusedStats      = accept ^ stall;
  assign stat_grants      = '0;
  assign stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mspe_dram_arbiter.sv
// tb_mspe_dram_arbiter: table-driven single transactions, hand-written
// rotation/spurious/reset sequences, then randomized traffic checked against
// a round-robin reference model.
module tb_mspe_dram_arbiter;

  localparam int CORES   = 4;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 512;
  localparam int BURST_W = 3;
  localparam int BE_W    = DATA_W / 8;
`ifdef MSPE_DRAM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [CORES-1:0]          req_read, req_write;
  logic [CORES*ADDR_W-1:0]   req_address;
  logic [CORES*BURST_W-1:0]  req_burstcount;
  logic [CORES*DATA_W-1:0]   req_writedata;
  logic [CORES*BE_W-1:0]     req_byteenable;
  logic [CORES-1:0]          req_ack;
  logic [DATA_W-1:0]         rsp_readdata;
  logic [CORES-1:0]          rsp_valid;
  logic                      err_spurious;
  logic                      m0_waitrequest;
  logic [DATA_W-1:0]         m0_readdata;
  logic                      m0_readdatavalid;
  logic [ADDR_W-1:0]         m0_address;
  logic [BURST_W-1:0]        m0_burstcount;
  logic [DATA_W-1:0]         m0_writedata;
  logic [BE_W-1:0]           m0_byteenable;
  logic                      m0_read, m0_write, m0_debugaccess;
  logic [CORES*32-1:0]       stat_grants;
  logic [31:0]               stat_wait_cycles;

  mspe_dram_arbiter #(
    .CORES(CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_read(req_read), .req_write(req_write), .req_address(req_address),
    .req_burstcount(req_burstcount), .req_writedata(req_writedata),
    .req_byteenable(req_byteenable), .req_ack(req_ack),
    .rsp_readdata(rsp_readdata), .rsp_valid(rsp_valid), .err_spurious(err_spurious),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_address(m0_address),
    .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_debugaccess(m0_debugaccess), .stat_grants(stat_grants),
    .stat_wait_cycles(stat_wait_cycles)
  );

  always #5 clk = ~clk;

  // Requester-side view and reference model state.
  logic [63:0]      coreAddr  [CORES];
  logic [2:0]       coreBurst [CORES];
  logic [63:0]      coreData  [CORES];
  logic [63:0]      coreBe    [CORES];
  logic [CORES-1:0] rdReq, wrReq;
  int               rrLast;
  int               expGrants [CORES];
  int               expWait;
  logic             errExp;
  int               vectors = 0;
  int               miscompares = 0;

  typedef struct {
    int         core;
    bit         isRd;
    logic [63:0] addr;
    logic [2:0] burst;
    int         waits;
    logic [2:0] expBurst;
    logic [3:0] expValid;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    req_read  = rdReq;
    req_write = wrReq;
    for (int i = 0; i < CORES; i++) begin
      req_address[i*ADDR_W +: ADDR_W]    = coreAddr[i];
      req_burstcount[i*BURST_W +: BURST_W] = coreBurst[i];
      req_writedata[i*DATA_W +: DATA_W]  = {8{coreData[i]}};
      req_byteenable[i*BE_W +: BE_W]     = coreBe[i];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    rrLast  = CORES - 1;
    expWait = 0;
    errExp  = 1'b0;
    for (int i = 0; i < CORES; i++) expGrants[i] = 0;
  endtask

  task automatic checkStats();
    for (int i = 0; i < CORES; i++)
      checkOutput("stat_grants", stat_grants[i*32 +: 32], STATS_ON ? 64'(expGrants[i]) : 64'd0);
    checkOutput("stat_wait_cycles", stat_wait_cycles, STATS_ON ? 64'(expWait) : 64'd0);
  endtask

  // First requester strictly after the last grant, wrapping around.
  function automatic int predict();
    for (int off = 1; off <= CORES; off++) begin
      int c = (rrLast + off) % CORES;
      if (rdReq[c] || wrReq[c]) return c;
    end
    return -1;
  endfunction

  // Expects one command from 'core' one clock after being called in IDLE,
  // stalls it 'waits' cycles, then returns the read beats.
  task automatic serveCmd(input int core, input bit isRd, input logic [2:0] expBurst,
                          input logic [3:0] expValid, input int waits);
    bit          seen = 0;
    int          lat = 0;
    logic [63:0] beat;
    m0_waitrequest = (waits > 0);
    for (int k = 0; k < 16 && !seen; k++) begin
      cycle();
      lat++;
      if (m0_read || m0_write) seen = 1;
    end
    if (!seen) begin
      checkOutput("cmd timeout", 64'd0, 64'd1);
      return;
    end
    checkOutput("cmd latency", 64'(lat), 64'd1);
    checkOutput("m0_read", m0_read, isRd);
    checkOutput("m0_write", m0_write, !isRd);
    checkOutput("m0_burstcount", m0_burstcount, expBurst);
    checkOutput("m0_debugaccess", m0_debugaccess, 1'b0);
    if (!isRd) begin
      checkOutput("m0_writedata lo", m0_writedata[63:0], coreData[core]);
      checkOutput("m0_writedata hi", m0_writedata[511:448], coreData[core]);
      checkOutput("m0_byteenable", m0_byteenable, coreBe[core]);
    end
    for (int w = 0; w <= waits; w++) begin
      m0_waitrequest = (w < waits);
      #1;
      checkOutput("req_ack", req_ack, (w == waits) ? (64'd1 << core) : 64'd0);
      checkOutput("m0_address stable", m0_address, coreAddr[core]);
      checkOutput("m0 cmd stable", {m0_read, m0_write}, {isRd, !isRd});
      cycle();
    end
    m0_waitrequest = 1'b0;
    if (isRd) rdReq[core] = 1'b0; else wrReq[core] = 1'b0;
    rrLast = core;
    expGrants[core]++;
    expWait += waits;
    for (int b = 0; b < (isRd ? int'(expBurst) : 0); b++) begin
      beat = {$urandom, $urandom};
      m0_readdatavalid = 1'b1;
      m0_readdata      = {8{beat}};
      cycle();
      checkOutput("rsp_valid", rsp_valid, expValid);
      checkOutput("rsp_readdata", rsp_readdata[63:0], beat);
    end
    m0_readdatavalid = 1'b0;
    checkOutput("m0 idle after txn", {m0_read, m0_write}, 2'b00);
    checkOutput("err_spurious", err_spurious, errExp);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    logic [2:0] eb;
    reset_n = 1'b0;
    rdReq = '0; wrReq = '0;
    for (int i = 0; i < CORES; i++) begin
      coreAddr[i] = 64'h100 * (i + 1); coreBurst[i] = 3'd1;
      coreData[i] = '0; coreBe[i] = '0;
    end
    m0_waitrequest = 1'b0; m0_readdata = '0; m0_readdatavalid = 1'b0;
    applyStimulus();
    resetModel();

    // Reset state.
    cycle(); cycle();
    checkOutput("reset m0_read/write", {m0_read, m0_write}, 2'b00);
    checkOutput("reset req_ack", req_ack, 0);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset err_spurious", err_spurious, 0);
    checkOutput("reset m0_address", m0_address, 0);
    checkOutput("reset m0_burstcount", m0_burstcount, 0);
    checkStats();
    reset_n = 1'b1;
    cycle();

    // All cores reading continuously: strict rotation starting at core 0.
    rdReq = '1;
    applyStimulus();
    for (int k = 0; k < 5; k++) begin
      serveCmd(k % CORES, 1'b1, 3'd1, 4'(1 << (k % CORES)), 0);
      rdReq = '1;
      if (k == 4) rdReq = '0;
      applyStimulus();
    end

    // Single transactions from the vector table.
    vecs[0] = '{2, 1'b1, 64'h1000, 3'd3, 0, 3'd3, 4'b0100};
    vecs[1] = '{1, 1'b0, 64'h2040, 3'd5, 5, 3'd1, 4'b0000};
    vecs[2] = '{0, 1'b1, 64'h3000, 3'd0, 0, 3'd1, 4'b0001};
    vecs[3] = '{3, 1'b1, 64'hDEAD_BEEF_0000_4000, 3'd4, 2, 3'd4, 4'b1000};
    vecs[4] = '{0, 1'b0, 64'h5080, 3'd2, 1, 3'd1, 4'b0000};
    for (int t = 0; t < 5; t++) begin
      c = vecs[t].core;
      coreAddr[c]  = vecs[t].addr;
      coreBurst[c] = vecs[t].burst;
      coreData[c]  = {$urandom, $urandom};
      coreBe[c]    = {$urandom, $urandom};
      if (vecs[t].isRd) rdReq[c] = 1'b1; else wrReq[c] = 1'b1;
      applyStimulus();
      #1;
      checkOutput("no same-cycle cmd", {m0_read, m0_write}, 2'b00);
      serveCmd(c, vecs[t].isRd, vecs[t].expBurst, vecs[t].expValid, vecs[t].waits);
      applyStimulus();
    end
    checkStats();

    // readdatavalid while idle: dropped, error sticks.
    m0_readdatavalid = 1'b1;
    m0_readdata = {8{64'hBAD0_BAD0_BAD0_BAD0}};
    cycle();
    m0_readdatavalid = 1'b0;
    errExp = 1'b1;
    checkOutput("spurious rsp_valid", rsp_valid, 0);
    checkOutput("spurious err set", err_spurious, 1);
    cycle(); cycle(); cycle();
    checkOutput("spurious err sticky", err_spurious, 1);

    // Reset after the first of four beats.
    coreBurst[2] = 3'd4;
    rdReq = 4'b0100;
    applyStimulus();
    cycle();
    checkOutput("rst-burst m0_read", m0_read, 1);
    checkOutput("rst-burst ack", req_ack, 4'b0100);
    cycle();
    rdReq = '0;
    applyStimulus();
    m0_readdatavalid = 1'b1;
    m0_readdata = {8{64'h5555_AAAA_1234_5678}};
    cycle();
    m0_readdatavalid = 1'b0;
    checkOutput("rst-burst beat1 valid", rsp_valid, 4'b0100);
    checkOutput("rst-burst beat1 data", rsp_readdata[63:0], 64'h5555_AAAA_1234_5678);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset rsp_valid", rsp_valid, 0);
    checkOutput("async reset rsp_readdata", rsp_readdata[63:0], 0);
    checkOutput("async reset err", err_spurious, 0);
    checkOutput("async reset m0 cmd", {m0_read, m0_write}, 2'b00);
    checkOutput("async reset m0_address", m0_address, 0);
    resetModel();
    checkStats();
    cycle();
    reset_n = 1'b1;
    m0_readdatavalid = 1'b1;
    cycle();
    m0_readdatavalid = 1'b0;
    errExp = 1'b1;
    checkOutput("late beat rsp_valid", rsp_valid, 0);
    checkOutput("late beat err", err_spurious, 1);
    coreBurst[0] = 3'd2;
    rdReq = '1;
    applyStimulus();
    serveCmd(0, 1'b1, 3'd2, 4'b0001, 0);
    rdReq = '0;
    applyStimulus();

    // Randomized traffic against the round-robin model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < CORES; i++) begin
        if (!rdReq[i] && !wrReq[i] && ($urandom_range(0, 1) == 1)) begin
          int r = $urandom_range(0, 3);
          coreAddr[i]  = {$urandom, $urandom};
          coreBurst[i] = 3'($urandom_range(0, 4));
          coreData[i]  = {$urandom, $urandom};
          coreBe[i]    = {$urandom, $urandom};
          if (r <= 1) rdReq[i] = 1'b1;
          else if (r == 2) wrReq[i] = 1'b1;
          else begin rdReq[i] = 1'b1; wrReq[i] = 1'b1; end
        end
      end
      if ((rdReq | wrReq) == '0) rdReq[n % CORES] = 1'b1;
      applyStimulus();
      c  = predict();
      eb = (rdReq[c] && (coreBurst[c] != 3'd0)) ? coreBurst[c] : 3'd1;
      serveCmd(c, rdReq[c], eb, 4'(1 << c), $urandom_range(0, 3));
      applyStimulus();
    end
    checkStats();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
